phase_accumulator: RTL and testbench

//  Generates the oscillator state/phase pair consumed by the Pulse waveform stage.
//  - Per sample tick, walks phase up (FRONT) then down (BACK) by a per-note increment,

---
 rtl/phase_accumulator.sv | 115 +++++++++++
 tb/tb_phase_accumulator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/phase_accumulator.sv
// Triangle phase accumulator: walks phase up (FRONT) then down (BACK), reflecting at both ends.
// Optional note_on retrigger is compiled in with `define PHASE_ACC_RETRIGGER_EN.
module phase_accumulator #(
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned INC_WIDTH   = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_sample_tick,
    input  logic                   i_enable,
    input  logic [INC_WIDTH-1:0]   i_increment,
    input  logic                   i_note_on,
    output logic                   o_state,
    output logic [PHASE_WIDTH-1:0] o_phase,
    output logic                   o_phase_valid,
    output logic                   o_period_start
);

    typedef enum logic {
        StFront = 1'b0,
        StBack  = 1'b1
    } osc_state_e;

    osc_state_e             r_state;
    osc_state_e             w_state_d;
    osc_state_e             w_base_state;
    logic [PHASE_WIDTH-1:0] r_phase;
    logic [PHASE_WIDTH-1:0] w_phase_d;
    logic [PHASE_WIDTH-1:0] w_base_phase;
    logic [PHASE_WIDTH-1:0] w_step;
    logic [PHASE_WIDTH:0]   w_sum;
    logic [PHASE_WIDTH:0]   w_diff;
    logic                   r_phase_valid;
    logic                   r_period_start;
    logic                   w_advance;
    logic                   w_retrig;
    logic                   w_period_start_d;

    // Oversized increments saturate to MAX rather than wrapping.
    generate
        if (INC_WIDTH > PHASE_WIDTH) begin : g_clamp
            assign w_step = (|i_increment[INC_WIDTH-1:PHASE_WIDTH]) ?
                            {PHASE_WIDTH{1'b1}} : i_increment[PHASE_WIDTH-1:0];
        end else begin : g_extend
            assign w_step = PHASE_WIDTH'(i_increment);
        end
    endgenerate

`ifdef PHASE_ACC_RETRIGGER_EN
    assign w_retrig = i_note_on;
`else
    logic w_unused_note_on;
    assign w_unused_note_on = i_note_on;
    assign w_retrig         = 1'b0;
`endif

    assign w_advance = i_sample_tick & i_enable;

    // A same-cycle tick advances from the retriggered origin.
    always_comb begin
        w_base_state = r_state;
        w_base_phase = r_phase;
        if (w_retrig) begin
            w_base_state = StFront;
            w_base_phase = '0;
        end
    end

    assign w_sum  = {1'b0, w_base_phase} + {1'b0, w_step};
    assign w_diff = {1'b0, w_base_phase} - {1'b0, w_step};

    always_comb begin
        w_state_d        = w_base_state;
        w_phase_d        = w_base_phase;
        w_period_start_d = w_retrig;
        if (w_advance) begin
            if (w_base_state == StFront) begin
                if (w_sum[PHASE_WIDTH]) begin
                    w_phase_d = ~w_sum[PHASE_WIDTH-1:0];
                    w_state_d = StBack;
                end else begin
                    w_phase_d = w_sum[PHASE_WIDTH-1:0];
                end
            end else begin
                if (w_diff[PHASE_WIDTH]) begin
                    w_phase_d        = w_step - w_base_phase;
                    w_state_d        = StFront;
                    w_period_start_d = 1'b1;
                end else begin
                    w_phase_d = w_diff[PHASE_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= StFront;
            r_phase        <= '0;
            r_phase_valid  <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_phase        <= w_phase_d;
            r_phase_valid  <= w_advance;
            r_period_start <= w_period_start_d;
        end
    end

    assign o_state        = r_state;
    assign o_phase        = r_phase;
    assign o_phase_valid  = r_phase_valid;
    assign o_period_start = r_period_start;

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed bench for phase_accumulator at PHASE_WIDTH=8, INC_WIDTH=9 (MAX=255).
module tb_phase_accumulator;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_sample_tick;
    logic       i_enable;
    logic [8:0] i_increment;
    logic       i_note_on;
    logic       o_state;
    logic [7:0] o_phase;
    logic       o_phase_valid;
    logic       o_period_start;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic FRONT = 1'b0;
    localparam logic BACK  = 1'b1;

    phase_accumulator #(
        .PHASE_WIDTH(8),
        .INC_WIDTH  (9)
    ) u_dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_sample_tick (i_sample_tick),
        .i_enable      (i_enable),
        .i_increment   (i_increment),
        .i_note_on     (i_note_on),
        .o_state       (o_state),
        .o_phase       (o_phase),
        .o_phase_valid (o_phase_valid),
        .o_period_start(o_period_start)
    );

    always #5 i_clock = ~i_clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one strobe starting at a falling edge; returns at the next falling edge.
    task automatic do_tick(input logic [8:0] inc, input logic en, input logic note);
        i_increment   = inc;
        i_enable      = en;
        i_sample_tick = 1'b1;
        i_note_on     = note;
        @(negedge i_clock);
        i_sample_tick = 1'b0;
        i_note_on     = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] ph, input logic st,
                             input logic vld, input logic ps);
        check_eq({tag, ".phase"}, 32'(o_phase), 32'(ph));
        check_eq({tag, ".state"}, 32'(o_state), 32'(st));
        check_eq({tag, ".valid"}, 32'(o_phase_valid), 32'(vld));
        check_eq({tag, ".pstart"}, 32'(o_period_start), 32'(ps));
    endtask

    initial begin
        i_reset       = 1'b1;
        i_sample_tick = 1'b0;
        i_enable      = 1'b0;
        i_increment   = '0;
        i_note_on     = 1'b0;
        repeat (2) @(negedge i_clock);
        check_out("reset", 8'd0, FRONT, 1'b0, 1'b0);
        i_reset = 1'b0;
        @(negedge i_clock);

        // Ticks while disabled are ignored.
        for (int i = 0; i < 5; i++) begin
            do_tick(9'd50, 1'b0, 1'b0);
            check_eq("dis.valid", 32'(o_phase_valid), 32'd0);
        end
        check_out("dis", 8'd0, FRONT, 1'b0, 1'b0);

        // Increment change without a tick has no effect.
        i_enable    = 1'b1;
        i_increment = 9'd77;
        @(negedge i_clock);
        check_out("noTick", 8'd0, FRONT, 1'b0, 1'b0);

        do_tick(9'd100, 1'b1, 1'b0);
        check_out("up1", 8'd100, FRONT, 1'b1, 1'b0);
        do_tick(9'd100, 1'b1, 1'b0);
        check_out("up2", 8'd200, FRONT, 1'b1, 1'b0);
        do_tick(9'd100, 1'b1, 1'b0);
        check_out("refTop", 8'd211, BACK, 1'b1, 1'b0);
        @(negedge i_clock);
        check_out("idle", 8'd211, BACK, 1'b0, 1'b0);

        do_tick(9'd11, 1'b1, 1'b0);
        check_out("down1", 8'd200, BACK, 1'b1, 1'b0);
        do_tick(9'd170, 1'b1, 1'b0);
        check_out("down2", 8'd30, BACK, 1'b1, 1'b0);
        do_tick(9'd100, 1'b1, 1'b0);
        check_out("refBot", 8'd70, FRONT, 1'b1, 1'b1);
        @(negedge i_clock);
        check_out("psDrop", 8'd70, FRONT, 1'b0, 1'b0);

        do_tick(9'd185, 1'b1, 1'b0);
        check_out("toMax", 8'd255, FRONT, 1'b1, 1'b0);
        do_tick(9'd55, 1'b1, 1'b0);
        check_out("fromMax", 8'd201, BACK, 1'b1, 1'b0);
        do_tick(9'd1, 1'b1, 1'b0);
        check_out("at200", 8'd200, BACK, 1'b1, 1'b0);

        do_tick(9'd10, 1'b1, 1'b1);
`ifdef PHASE_ACC_RETRIGGER_EN
        check_out("retrig", 8'd10, FRONT, 1'b1, 1'b1);
`else
        check_out("noRetrig", 8'd190, BACK, 1'b1, 1'b0);
`endif

        // Zero step: phase holds but the strobe still fires.
        @(negedge i_clock);
        begin
            logic [7:0] held_ph;
            logic       held_st;
            held_ph = o_phase;
            held_st = o_state;
            do_tick(9'd0, 1'b1, 1'b0);
            check_out("zeroStep", held_ph, held_st, 1'b1, 1'b0);
        end

        // Oversized increment clamps to MAX.
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        do_tick(9'h1FF, 1'b1, 1'b0);
        check_out("clamp1", 8'd255, FRONT, 1'b1, 1'b0);
        do_tick(9'h1FF, 1'b1, 1'b0);
        check_out("clamp2", 8'd1, BACK, 1'b1, 1'b0);
        do_tick(9'h1FF, 1'b1, 1'b0);
        check_out("clamp3", 8'd254, FRONT, 1'b1, 1'b1);

        // Asynchronous reset between clock edges.
        do_tick(9'd0, 1'b1, 1'b0);
        check_eq("preRst.valid", 32'(o_phase_valid), 32'd1);
        #2 i_reset = 1'b1;
        #1 check_out("asyncRst", 8'd0, FRONT, 1'b0, 1'b0);
        @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
